// File: rtl/alarm_controller.sv
// Alarm session controller: turns an alarm-match trigger into a ringing session
// with a buzzer square wave, a bounded number of snoozes and a dismiss control.
//
// state   | meaning
// IDLE    | no alarm activity, buzzer silent
// RINGING | buzzer toggling, ring timeout counting down
// SNOOZE  | buzzer silent, snooze countdown running
module alarm_controller #(
  parameter int BUZZ_DIV         = 100,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int SNOOZE_SEC       = 300,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       trigger,
  input  logic       armed,
  input  logic       snooze_btn,
  input  logic       dismiss_btn,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_count
);

  localparam int SEC_MAX = (RING_TIMEOUT_SEC > SNOOZE_SEC) ? RING_TIMEOUT_SEC : SNOOZE_SEC;
  localparam int SEC_W   = $clog2(SEC_MAX + 1);
  localparam int DIV_W   = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [1:0]         cnt_d;
  logic               buz_d;
  logic               trig_q, snz_q, dis_q;
  logic               trig_rise, snz_rise, dis_rise;

  assign trig_rise = trigger & ~trig_q;
  assign snz_rise  = snooze_btn & ~snz_q;
  assign dis_rise  = dismiss_btn & ~dis_q;

  // trig_q resets high so a trigger already asserted at reset release is not an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_q <= 1'b1;
      snz_q  <= 1'b0;
      dis_q  <= 1'b0;
    end else begin
      trig_q <= trigger;
      snz_q  <= snooze_btn;
      dis_q  <= dismiss_btn;
    end
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    cnt_d   = snooze_count;
    div_d   = '0;
    buz_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_rise && armed) begin
          state_d = RINGING;
          sec_d   = SEC_W'(RING_TIMEOUT_SEC);
          cnt_d   = 2'd0;
        end
      end
      RINGING: begin
        if (!armed || dis_rise) begin
          state_d = IDLE;
        end else if (snz_rise && (snooze_count < 2'(MAX_SNOOZE))) begin
          state_d = SNOOZE;
          sec_d   = SEC_W'(SNOOZE_SEC);
          cnt_d   = snooze_count + 2'd1;
        end else if (tick_1hz) begin
          if (sec_q == SEC_W'(1)) state_d = IDLE;
          else                    sec_d   = sec_q - SEC_W'(1);
        end
        // divider only advances while staying in RINGING; any exit forces it to 0
        if (state_d == RINGING) begin
          if (div_q == DIV_W'(BUZZ_DIV - 1)) begin
            div_d = '0;
            buz_d = ~buzzer;
          end else begin
            div_d = div_q + DIV_W'(1);
            buz_d = buzzer;
          end
        end
      end
      SNOOZE: begin
        if (!armed || dis_rise) begin
          state_d = IDLE;
        end else if (tick_1hz) begin
          if (sec_q == SEC_W'(1)) begin
            state_d = RINGING;
            sec_d   = SEC_W'(RING_TIMEOUT_SEC);
          end else begin
            sec_d = sec_q - SEC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) cnt_d = 2'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sec_q        <= '0;
      div_q        <= '0;
      buzzer       <= 1'b0;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
      snooze_count <= 2'd0;
    end else begin
      state_q      <= state_d;
      sec_q        <= sec_d;
      div_q        <= div_d;
      buzzer       <= buz_d;
      ringing      <= (state_d == RINGING);
      snoozing     <= (state_d == SNOOZE);
      snooze_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios then random stimulus, all
// compared each cycle against a behavioural model of the alarm session rules.
module tb_alarm_controller;

  localparam int BD = 2;
  localparam int RT = 5;
  localparam int SS = 3;
  localparam int MX = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       trigger = 1'b0;
  logic       armed = 1'b1;
  logic       snooze_btn = 1'b0;
  logic       dismiss_btn = 1'b0;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model: session phase, remaining seconds, snoozes used,
  // clocks spent in the current buzzer half-period, buzzer level
  localparam int P_OFF = 0, P_RING = 1, P_SNZ = 2;
  int m_phase, m_left, m_used, m_half, m_buz;
  bit m_prev_trig, m_prev_snz, m_prev_dis;

  alarm_controller #(
    .BUZZ_DIV(BD), .RING_TIMEOUT_SEC(RT), .SNOOZE_SEC(SS), .MAX_SNOOZE(MX)
  ) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .trigger(trigger),
    .armed(armed), .snooze_btn(snooze_btn), .dismiss_btn(dismiss_btn),
    .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing),
    .snooze_count(snooze_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = P_OFF; m_left = 0; m_used = 0; m_half = 0; m_buz = 0;
    m_prev_trig = 1'b1; m_prev_snz = 1'b0; m_prev_dis = 1'b0;
  endtask

  task automatic model_silence();
    m_phase = P_OFF; m_used = 0; m_half = 0; m_buz = 0;
  endtask

  task automatic start_ring();
    m_phase = P_RING; m_left = RT; m_half = 0; m_buz = 0;
  endtask

  task automatic model_step();
    bit tr, sr, dr;
    tr = trigger && !m_prev_trig;
    sr = snooze_btn && !m_prev_snz;
    dr = dismiss_btn && !m_prev_dis;
    m_prev_trig = trigger; m_prev_snz = snooze_btn; m_prev_dis = dismiss_btn;
    case (m_phase)
      P_OFF: if (tr && armed) begin start_ring(); m_used = 0; end
      P_RING: begin
        if (!armed || dr) model_silence();
        else if (sr && m_used < MX) begin
          m_phase = P_SNZ; m_left = SS; m_used++; m_half = 0; m_buz = 0;
        end else if (tick_1hz) begin
          if (m_left == 1) model_silence();
          else m_left--;
        end
        if (m_phase == P_RING) begin
          m_half++;
          if (m_half == BD) begin m_half = 0; m_buz = !m_buz; end
        end
      end
      default: begin
        if (!armed || dr) model_silence();
        else if (tick_1hz) begin
          if (m_left == 1) start_ring();
          else m_left--;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("ringing", ringing, (m_phase == P_RING));
    chk("snoozing", snoozing, (m_phase == P_SNZ));
    chk("buzzer", buzzer, m_buz);
    chk("snooze_count", snooze_count, m_used);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_step();
    cyc++;
    #1;
    compare_all();
    tick_1hz = ((cyc % 10) == 9);
  endtask

  task automatic press_snooze();
    snooze_btn = 1'b1; cycle(); snooze_btn = 1'b0;
  endtask

  task automatic press_dismiss();
    dismiss_btn = 1'b1; cycle(); dismiss_btn = 1'b0;
  endtask

  task automatic ring_now();
    trigger = 1'b1; cycle(); trigger = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    chk("reset_ringing", ringing, 0);
    chk("reset_buzzer", buzzer, 0);
    chk("reset_count", snooze_count, 0);
    @(posedge clk); #3 reset = 1'b1;
    repeat (3) cycle();

    // basic ring and timeout
    trigger = 1'b1; cycle();
    chk("entry_ringing", ringing, 1);
    trigger = 1'b0;
    cycle(); cycle();
    chk("first_toggle", buzzer, 1);
    repeat (60) cycle();
    chk("timeout_ringing", ringing, 0);
    chk("timeout_buzzer", buzzer, 0);

    // snooze cycle and snooze limit
    ring_now();
    repeat (4) cycle();
    press_snooze();
    chk("snz1_snoozing", snoozing, 1);
    chk("snz1_count", snooze_count, 1);
    repeat (35) cycle();
    chk("rering1", ringing, 1);
    chk("rering1_count", snooze_count, 1);
    press_snooze();
    chk("snz2_count", snooze_count, 2);
    repeat (35) cycle();
    chk("rering2", ringing, 1);
    press_snooze();
    chk("limit_ringing", ringing, 1);
    chk("limit_count", snooze_count, 2);
    press_dismiss();
    chk("dismiss_ringing", ringing, 0);
    chk("dismiss_count", snooze_count, 0);
    repeat (5) cycle();

    // snooze, dismiss and tick together
    ring_now();
    for (int i = 0; i < 20 && !tick_1hz; i++) cycle();
    snooze_btn = 1'b1; dismiss_btn = 1'b1;
    cycle();
    chk("simul_ringing", ringing, 0);
    chk("simul_snoozing", snoozing, 0);
    chk("simul_count", snooze_count, 0);
    snooze_btn = 1'b0; dismiss_btn = 1'b0;
    repeat (3) cycle();

    // trigger held across dismiss, disarmed trigger, disarm in snooze
    trigger = 1'b1; cycle();
    repeat (3) cycle();
    press_dismiss();
    repeat (10) cycle();
    chk("held_trig_no_rering", ringing, 0);
    trigger = 1'b0; cycle();
    armed = 1'b0;
    ring_now();
    cycle();
    chk("disarmed_no_ring", ringing, 0);
    armed = 1'b1; cycle();
    ring_now();
    press_snooze();
    chk("pre_disarm_snoozing", snoozing, 1);
    armed = 1'b0; cycle();
    chk("disarm_snoozing", snoozing, 0);
    armed = 1'b1; repeat (3) cycle();

    // reset mid-ring with trigger still high
    trigger = 1'b1; cycle();
    repeat (5) cycle();
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_ringing", ringing, 0);
    chk("async_rst_buzzer", buzzer, 0);
    chk("async_rst_count", snooze_count, 0);
    repeat (2) cycle();
    #2 reset = 1'b1;
    repeat (12) cycle();
    chk("post_rst_idle", ringing, 0);
    trigger = 1'b0;
    repeat (2) cycle();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      armed = ($urandom_range(0, 99) < 96);
      if ($urandom_range(0, 99) < 6) trigger = ~trigger;
      snooze_btn  = ($urandom_range(0, 99) < 8);
      dismiss_btn = ($urandom_range(0, 99) < 2);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Consumer of the clock's alarm-match `trigger`. It turns a match into a ringing session with a buzzer square wave, a snooze countdown and a dismiss control. It sits between the time-keeping counter block and the board buzzer/LEDs, and runs on the same system clock as the rest of the design.

## Interface
Parameters:
- `BUZZ_DIV`, 100: clk cycles per buzzer half-period; must be ≥1.
- `RING_TIMEOUT_SEC`, 60: seconds of unanswered ringing before auto-dismiss; must be ≥1.
- `SNOOZE_SEC`, 300: snooze length in seconds; must be ≥1.
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event; range 0..3.

Ports:
- `clk`, in, 1: system clock. One clock for the whole block.
- `reset`, in, 1: asynchronous, active-low reset.
- `tick_1hz`, in, 1: one-clk-wide strobe, once per second.
- `trigger`, in, 1: alarm-match level from the clock block. High for the whole matching second.
- `armed`, in, 1: alarm enable switch, synchronous level.
- `snooze_btn`, in, 1: debounced level. The block acts on its rising edge.
- `dismiss_btn`, in, 1: debounced level. The block acts on its rising edge.
- `buzzer`, out, 1: square wave while ringing, 0 otherwise.
- `ringing`, out, 1: high in RINGING.
- `snoozing`, out, 1: high in SNOOZE.
- `snooze_count`, out, 2: snoozes used in the current event.

## Operation
- Edge detection:
  - Registered copies of `trigger`, `snooze_btn` and `dismiss_btn` give rising edges `trig_rise`, `snz_rise` and `dis_rise`.
  - The `trigger` copy resets to 1, so a trigger that is already high at reset release does not fire.
  - The button copies reset to 0.
- States: IDLE, RINGING, SNOOZE. All registered outputs reset to 0, the state resets to IDLE, and all counters reset to 0.
- IDLE:
  - `trig_rise` && `armed` → RINGING.
  - On entry to RINGING: `sec_cnt` = `RING_TIMEOUT_SEC`, `snooze_count` = 0, buzzer divider = 0, `buzzer` = 0.
- RINGING, in priority order:
  1. `!armed` → IDLE.
  2. `dis_rise` → IDLE.
  3. `snz_rise` && `snooze_count` < `MAX_SNOOZE` → SNOOZE, `sec_cnt` = `SNOOZE_SEC`, `snooze_count`++.
  4. `tick_1hz` with `sec_cnt` == 1 → IDLE (timeout).
  5. `tick_1hz` otherwise: `sec_cnt`--.
  - A `snz_rise` when `snooze_count` == `MAX_SNOOZE` is ignored and ringing continues.
- SNOOZE, in priority order:
  1. `!armed` → IDLE.
  2. `dis_rise` → IDLE.
  3. `tick_1hz` with `sec_cnt` == 1 → RINGING, `sec_cnt` = `RING_TIMEOUT_SEC`, `snooze_count` held.
  4. `tick_1hz` otherwise: `sec_cnt`--.
  - `snz_rise` is ignored in SNOOZE.
- `trig_rise` in RINGING or SNOOZE is ignored: there is no restart and no counter reload.
- Any transition to IDLE clears `snooze_count` to 0 and drives `buzzer` to 0 on the same edge.
- Buzzer:
  - In RINGING, the divider counts 0..`BUZZ_DIV`-1.
  - On the terminal count it wraps to 0 and toggles `buzzer`.
  - Outside RINGING, the divider is held at 0 and `buzzer` is 0.
- Width rules:
  - `sec_cnt` is wide enough for max(`RING_TIMEOUT_SEC`, `SNOOZE_SEC`).
  - The buzzer divider is wide enough for `BUZZ_DIV`-1.
  - No counter wraps below 0, because the terminal checks fire at 1.

## Timing
- All outputs are registered.
- Latency:
  - `trigger` rising at edge k is captured at k. `ringing` goes high at k+1.
  - The first `buzzer` toggle is at k+1+`BUZZ_DIV`.
- A button rising edge sampled at edge k changes state, and `ringing`/`snoozing`, at k+1.
- Ring duration with no input: exactly `RING_TIMEOUT_SEC` `tick_1hz` strobes after entry. `ringing` drops the cycle after the last strobe.
- Snooze duration: exactly `SNOOZE_SEC` strobes.
- A `tick_1hz` in the entry cycle of a state is counted.
- Simultaneous events:
  - Dismiss beats snooze.
  - Any button beats the tick; the tick is dropped.
  - `!armed` beats everything.
- Reset asserted mid-ring: outputs go to 0 asynchronously, with no glitch on release. `trigger` still high after release does not re-ring.

## Test plan
All scenarios use `BUZZ_DIV`=2, `RING_TIMEOUT_SEC`=5, `SNOOZE_SEC`=3, `MAX_SNOOZE`=2, and a tick every 10 clks.
- Basic ring: `armed`=1, pulse `trigger` → `ringing`=1 one clk later; `buzzer` toggles every 2 clks; after the 5th tick, `ringing`=0 and `buzzer`=0.
- Snooze cycle: ring, then `snooze_btn` rise → `snoozing`=1 and `snooze_count`=1; after 3 ticks, `ringing`=1 and `snooze_count` stays 1.
- Snooze limit: snooze twice, then press snooze a third time while ringing → stays RINGING, `snooze_count`=2. Dismiss → IDLE, `snooze_count`=0.
- Simultaneous events: `snooze_btn` and `dismiss_btn` rise on the same clk as `tick_1hz` → IDLE, `snooze_count`=0.
- Retrigger and disarm: `trigger` held high across dismiss → no re-ring. `trigger` rise with `armed`=0 → no ring. Drop `armed` during SNOOZE → IDLE next clk.
- Reset: assert `reset`=0 mid-ring with `trigger` high → all outputs 0 immediately; after release with `trigger` still high → stays IDLE.
